// File: rtl/aclk_keybuf_n_if.sv
`default_nettype none
// ============================================================================
// Module   : aclk_keybuf_n_if
// Purpose  : Bus between the key decoder, the keypad entry buffer and the
//            alarm/time load path. The master drives the key value and the
//            command strobes. The slave returns the buffer contents and
//            status.
// Revision : 1.0  initial release
// ============================================================================
interface aclk_keybuf_n_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int CNT_W      = 4
);
  logic [DIGIT_W-1:0]            key;
  logic                          shift;
  logic                          backspace;
  logic                          clear;
  logic                          tick;
  logic [NUM_DIGITS*DIGIT_W-1:0] key_buffer;
  logic [CNT_W-1:0]              digit_count;
  logic                          full;
  logic                          empty;
  logic                          key_err;
  logic                          timeout;

  modport master (
    output key, shift, backspace, clear, tick,
    input  key_buffer, digit_count, full, empty, key_err, timeout
  );

  modport slave (
    input  key, shift, backspace, clear, tick,
    output key_buffer, digit_count, full, empty, key_err, timeout
  );
endinterface
`default_nettype wire

// File: rtl/aclk_keybuf_n.sv
`default_nettype none
// ============================================================================
// Module   : aclk_keybuf_n
// Purpose  : Parametrised keypad entry buffer for the alarm clock. Digit 0
//            holds the most recent key. The buffer supports digit counting,
//            BCD range checking, backspace, clear, and full/overwrite
//            handling.
// Option   : define ACLK_KEYBUF_TIMEOUT_EN to enable the inactivity
//            auto-clear. This feature is driven by tick.
// Revision : 1.0  initial release
// ============================================================================
module aclk_keybuf_n #(
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_W       = 4,
  parameter int MAX_DIGIT     = 9,
  parameter int OVERWRITE     = 0,
  parameter int TIMEOUT_TICKS = 10,
  parameter int CNT_W         = 4
) (
  input  logic           clk,
  input  logic           reset,
  aclk_keybuf_n_if.slave bus
);

  localparam int               c_BUF_W     = NUM_DIGITS * DIGIT_W;
  localparam logic [CNT_W-1:0] c_FULL_CNT  = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  // The effective buffer state is decoded from the digit count only.
  localparam logic [1:0] c_ST_EMPTY   = 2'd0;
  localparam logic [1:0] c_ST_PARTIAL = 2'd1;
  localparam logic [1:0] c_ST_FULL    = 2'd2;

  logic [c_BUF_W-1:0] r_buf;
  logic [CNT_W-1:0]   r_count;
  logic               r_key_err;

  logic [1:0]         w_state;
  logic               w_key_ok;
  logic [c_BUF_W-1:0] w_shift_up;
  logic [c_BUF_W-1:0] w_shift_dn;
  logic [c_BUF_W-1:0] w_buf_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_err_nxt;

`ifdef ACLK_KEYBUF_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_TO_LIMIT = CNT_W'(TIMEOUT_TICKS);
  logic [CNT_W-1:0]   r_tcnt;
  logic               r_timeout;
  logic [CNT_W-1:0]   w_tcnt_nxt;
  logic               w_to_nxt;
`endif

  // The key value is accepted only when it is a legal digit. It is zero-extended before the compare.
  assign w_key_ok   = (int'(bus.key) <= MAX_DIGIT);
  // New key enters at digit 0. The oldest digit drops off the top.
  assign w_shift_up = {r_buf[c_BUF_W-DIGIT_W-1:0], bus.key};
  // Backspace pulls every digit down one slot. The top slot is filled with zero.
  assign w_shift_dn = {{DIGIT_W{1'b0}}, r_buf[c_BUF_W-1:DIGIT_W]};

  // Decode EMPTY / PARTIAL / FULL from the digit count.
  always_comb begin
    w_state = c_ST_PARTIAL;
    if (r_count == '0) begin
      w_state = c_ST_EMPTY;
    end else if (r_count == c_FULL_CNT) begin
      w_state = c_ST_FULL;
    end
  end

  // Resolve the command for this cycle with priority clear > backspace > shift, then apply the inactivity timeout.
  always_comb begin
    w_buf_nxt   = r_buf;
    w_count_nxt = r_count;
    w_err_nxt   = 1'b0;
`ifdef ACLK_KEYBUF_TIMEOUT_EN
    w_tcnt_nxt  = r_tcnt;
    w_to_nxt    = 1'b0;
`endif
    if (bus.clear) begin
      w_buf_nxt   = '0;
      w_count_nxt = '0;
    end else if (bus.backspace) begin
      if (w_state != c_ST_EMPTY) begin
        w_buf_nxt   = w_shift_dn;
        w_count_nxt = r_count - c_ONE;
      end
    end else if (bus.shift) begin
      if (!w_key_ok) begin
        w_err_nxt = 1'b1;
      end else if (w_state != c_ST_FULL) begin
        w_buf_nxt   = w_shift_up;
        w_count_nxt = r_count + c_ONE;
      end else if (OVERWRITE != 0) begin
        w_buf_nxt   = w_shift_up;
      end else begin
        w_err_nxt   = 1'b1;
      end
    end
`ifdef ACLK_KEYBUF_TIMEOUT_EN
    // Any strobe counts as activity, including a rejected shift. A strobe also wins over a tick in the same cycle.
    if (bus.clear || bus.backspace || bus.shift) begin
      w_tcnt_nxt = '0;
    end else if (w_state == c_ST_EMPTY) begin
      w_tcnt_nxt = '0;
    end else if (bus.tick) begin
      if (r_tcnt + c_ONE == c_TO_LIMIT) begin
        w_buf_nxt   = '0;
        w_count_nxt = '0;
        w_tcnt_nxt  = '0;
        w_to_nxt    = 1'b1;
      end else begin
        w_tcnt_nxt  = r_tcnt + c_ONE;
      end
    end
`endif
  end

  // Buffer, count and the key_err pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf     <= '0;
      r_count   <= '0;
      r_key_err <= 1'b0;
    end else begin
      r_buf     <= w_buf_nxt;
      r_count   <= w_count_nxt;
      r_key_err <= w_err_nxt;
    end
  end

`ifdef ACLK_KEYBUF_TIMEOUT_EN
  // Inactivity counter and the timeout pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tcnt    <= w_tcnt_nxt;
      r_timeout <= w_to_nxt;
    end
  end

  assign bus.timeout = r_timeout;
`else
  // Without the timeout feature, tick and the tick limit have no function.
  logic w_unused_tick;
  assign w_unused_tick = &{1'b0, bus.tick, CNT_W'(TIMEOUT_TICKS)};
  assign bus.timeout   = 1'b0;
`endif

  assign bus.key_buffer  = r_buf;
  assign bus.digit_count = r_count;
  assign bus.key_err     = r_key_err;
  assign bus.full        = (w_state == c_ST_FULL);
  assign bus.empty       = (w_state == c_ST_EMPTY);

endmodule
`default_nettype wire

// File: doc/aclk_keybuf_n.md
Name: aclk_keybuf_n

Overview:
- Parametrised keypad entry buffer for the alarm clock. Successor to the fixed 4-digit key shift register.
- Captures up to NUM_DIGITS BCD digits from the key decoder on shift pulses.
- Adds digit counting, BCD validation, backspace, clear, full/overwrite handling and an optional inactivity timeout.
- Feeds the alarm/time load path. Digit 0 is the most recently entered key, i.e. the least-significant minute digit when NUM_DIGITS=4.

Parameters:
- NUM_DIGITS, 4: number of digit slots (2..8).
- DIGIT_W, 4: bits per digit.
- MAX_DIGIT, 9: largest accepted key value. Keys above this are rejected.
- OVERWRITE, 0: 1 = shift when full discards the oldest digit; 0 = shift when full is rejected.
- TIMEOUT_TICKS, 10: tick pulses of inactivity before auto-clear (used only with the optional feature).
- CNT_W, 4: width of digit_count and the timeout counter. Must hold NUM_DIGITS and TIMEOUT_TICKS.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- key, input, DIGIT_W: decoded key value, sampled when shift=1.
- shift, input, 1: single-cycle strobe; push key into digit 0.
- backspace, input, 1: single-cycle strobe; remove the most recent digit.
- clear, input, 1: single-cycle strobe; empty the buffer.
- tick, input, 1: one-cycle timebase pulse (1 Hz enable).
- key_buffer, output, NUM_DIGITS*DIGIT_W: digit i occupies bits [i*DIGIT_W +: DIGIT_W].
- digit_count, output, CNT_W: number of valid digits, 0..NUM_DIGITS.
- full, output, 1: digit_count == NUM_DIGITS.
- empty, output, 1: digit_count == 0.
- key_err, output, 1: one-cycle pulse when a shift is rejected.
- timeout, output, 1: one-cycle pulse on auto-clear.

Behaviour:
- Reset (asynchronous, immediate):
  - key_buffer=0, digit_count=0, timeout counter=0.
  - key_err=0, timeout=0, full=0, empty=1.
- All updates happen on the clk rising edge. full and empty are combinational from digit_count. key_err and timeout are registered pulses.
- Effective state is derived from digit_count: EMPTY (0), PARTIAL (1..N-1), FULL (N).
- Command priority per cycle: clear > backspace > shift. Lower-priority strobes in the same cycle are ignored silently (no key_err).
- clear: key_buffer=0, digit_count=0. Legal in any state.
- backspace:
  - Digit i takes digit i+1; the top digit becomes 0; digit_count decrements.
  - In EMPTY it is a no-op.
- shift with key <= MAX_DIGIT:
  - EMPTY/PARTIAL: digit i+1 takes digit i; digit 0 takes key; digit_count increments.
  - FULL with OVERWRITE=1: same shift, the oldest digit is lost, digit_count stays N.
  - FULL with OVERWRITE=0: buffer unchanged; key_err=1 next cycle.
- shift with key > MAX_DIGIT: buffer and count unchanged; key_err=1 next cycle.
- A rejected shift still counts as activity for the timeout.
- Latency: key_buffer and digit_count reflect a command one cycle after the strobe. Back-to-back strobes on consecutive cycles are each honoured.
- digit_count never exceeds NUM_DIGITS and never goes below 0.

Optional Feature:
- Macro: ACLK_KEYBUF_TIMEOUT_EN.
- Defined:
  - The timeout counter increments on each tick while digit_count > 0.
  - Any shift, backspace or clear strobe resets the counter to 0. If a strobe and a tick land in the same cycle, the strobe wins and the counter goes to 0.
  - When the counter reaches TIMEOUT_TICKS: buffer and count clear, the counter resets, and timeout pulses for one cycle.
  - The counter holds at 0 while EMPTY.
- Undefined: no counter logic; the timeout output is tied to 0 and tick is ignored.

Test Plan:
- Reset, then shift keys 1,2,3,0 → key_buffer=16'h1230, digit_count=4, full=1, key_err=0.
- Full with OVERWRITE=0, shift 7 → key_buffer=16'h1230, key_err pulses 1 cycle. Same case with OVERWRITE=1 → key_buffer=16'h2307, digit_count=4.
- Buffer 16'h0123 (count 3), backspace → 16'h0012, count 2. Three further backspaces → 16'h0000, count 0, empty=1, no underflow.
- Shift key=4'hB → buffer unchanged, key_err=1. shift+clear in the same cycle → buffer 0, count 0, key_err=0.
- TIMEOUT_EN, TIMEOUT_TICKS=3: enter digit 5, then 3 ticks → one timeout pulse after the 3rd tick, buffer 0, empty=1. A shift on the 2nd tick restarts the count.
- Assert reset mid-entry (count 2) asynchronously between edges → outputs go to reset values immediately; the next shift of 8 gives key_buffer=16'h0008, count 1.
